// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default sample width, frame geometry and
// the complex sample type used by the serial-to-parallel front end.
package fft_pkg;

  localparam int DATA_WIDTH_DEF = 21;
  localparam int GROUPS_DEF     = 2048;

  // A single-group frame still needs a one-bit label to stay a legal vector.
  function automatic int label_width(input int groups);
    return (groups > 1) ? $clog2(groups) : 1;
  endfunction

  localparam int LABEL_W_DEF = label_width(GROUPS_DEF);

  typedef struct packed {
    logic signed [DATA_WIDTH_DEF-1:0] re;
    logic signed [DATA_WIDTH_DEF-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft4_s2p_packer.sv
// Packs a serial complex stream into 4-sample groups for a radix-4 FFT stage,
// labelling each group with its index within the frame.
module fft4_s2p_packer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int GROUPS     = GROUPS_DEF,
  localparam int LABEL_W   = label_width(GROUPS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_sop,
  input  logic signed [DATA_WIDTH-1:0] in_r,
  input  logic signed [DATA_WIDTH-1:0] in_i,
  output logic                         valid,
  output logic        [LABEL_W-1:0]    lable,
  output logic signed [DATA_WIDTH-1:0] x0_r,
  output logic signed [DATA_WIDTH-1:0] x0_i,
  output logic signed [DATA_WIDTH-1:0] x1_r,
  output logic signed [DATA_WIDTH-1:0] x1_i,
  output logic signed [DATA_WIDTH-1:0] x2_r,
  output logic signed [DATA_WIDTH-1:0] x2_i,
  output logic signed [DATA_WIDTH-1:0] x3_r,
  output logic signed [DATA_WIDTH-1:0] x3_i,
  output logic                         frame_done,
  output logic                         sop_err
);

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } smp_t;

  localparam logic [LABEL_W-1:0] LAST_GRP = LABEL_W'(GROUPS - 1);

  smp_t               cap0_p0, cap1_p0, cap2_p0;
  logic [1:0]         slot;
  logic [LABEL_W-1:0] grp;
  logic [1:0]         eff_slot;
  smp_t               cur;

  // A start-of-packet always lands in slot 0, abandoning any partial group.
  always_comb begin
    eff_slot = in_sop ? 2'd0 : slot;
    cur.re   = in_r;
    cur.im   = in_i;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      slot       <= 2'd0;
      grp        <= '0;
      cap0_p0    <= '0;
      cap1_p0    <= '0;
      cap2_p0    <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      sop_err    <= 1'b0;
      lable      <= '0;
      x0_r <= '0; x0_i <= '0; x1_r <= '0; x1_i <= '0;
      x2_r <= '0; x2_i <= '0; x3_r <= '0; x3_i <= '0;
    end else begin
      valid      <= 1'b0;
      frame_done <= 1'b0;
      sop_err    <= in_valid & in_sop & (slot != 2'd0);
      lable      <= '0;
      x0_r <= '0; x0_i <= '0; x1_r <= '0; x1_i <= '0;
      x2_r <= '0; x2_i <= '0; x3_r <= '0; x3_i <= '0;

      if (in_valid) begin
        slot <= eff_slot + 2'd1;
        if (in_sop)
          grp <= '0;
        case (eff_slot)
          2'd0: cap0_p0 <= cur;
          2'd1: cap1_p0 <= cur;
          2'd2: cap2_p0 <= cur;
          default: begin
            // p1: slot-3 sample joins the captured three on the output registers
            valid      <= 1'b1;
            lable      <= grp;
            frame_done <= (grp == LAST_GRP);
            grp        <= (grp == LAST_GRP) ? '0 : grp + LABEL_W'(1);
            x0_r <= cap0_p0.re; x0_i <= cap0_p0.im;
            x1_r <= cap1_p0.re; x1_i <= cap1_p0.im;
            x2_r <= cap2_p0.re; x2_i <= cap2_p0.im;
            x3_r <= cur.re;     x3_i <= cur.im;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/fft4_s2p_packer.md
FFT4_S2P_PACKER -- requirements
Module: fft4_s2p_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 21, is the signed width of each real/imag sample component.
REQ-002 Parameter GROUPS, default 2048, is the number of 4-sample groups per frame; LABEL_W = $clog2(GROUPS), which is 11 at the default.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  synchronous reset, asserted high; the name follows codebase port naming only.
REQ-006 in_valid  input  1  a serial complex sample is presented this cycle.
REQ-007 in_sop  input  1  qualifies the current sample as sample 0 of a frame; meaningful only when in_valid=1.
REQ-008 in_r, in_i  input  DATA_WIDTH each  signed serial sample, real and imaginary parts.
REQ-009 valid  output  1  one-cycle pulse: a packed group is present on x*_r/x*_i.
REQ-010 lable  output  LABEL_W  group number within the frame, 0..GROUPS-1.
REQ-011 x0_r, x0_i, x1_r, x1_i, x2_r, x2_i, x3_r, x3_i  output  DATA_WIDTH each  signed packed group, in arrival order x0..x3.
REQ-012 frame_done  output  1  pulses together with valid on the group whose lable = GROUPS-1.
REQ-013 sop_err  output  1  one-cycle pulse: in_sop arrived while a group was partially filled.

Function
REQ-014 A 2-bit slot counter increments on every cycle with in_valid=1 and wraps 3->0; it holds while in_valid=0.
REQ-015 Gaps in in_valid of any length are permitted; partial-group contents and the slot counter are held across gaps.
REQ-016 Samples in slots 0..2 are stored in capture registers; the slot-3 sample goes directly into the output registers together with the three captured samples.
REQ-017 Latency: valid=1 exactly one cycle after the clock edge that accepts the slot-3 sample.
REQ-018 Packing: x0 = slot 0, x1 = slot 1, x2 = slot 2, x3 = slot 3; values pass through bit-exact, with no scaling or rounding.
REQ-019 The group counter drives lable with the value for the group just completed, then increments after emission and wraps GROUPS-1 -> 0.
REQ-020 frame_done is asserted in the same cycle as the valid whose lable = GROUPS-1.
REQ-021 When valid=0, all x* outputs and lable shall be driven to zero, matching the downstream zero-when-idle expectation.
REQ-022 in_sop with in_valid=1 forces this sample into slot 0, clears the group counter to 0, and discards any partial group.
REQ-023 If in_sop with in_valid=1 arrives while slot != 0, sop_err pulses one cycle later; an in_sop at slot 0 gives no error.
REQ-024 in_sop with in_valid=0 is ignored.
REQ-025 Sustained input rate is one sample per cycle, giving one valid pulse every 4 cycles with no stall and no data loss; the block has no backpressure.
REQ-026 An in_sop that lands exactly on a group boundary, following a complete group, emits that group normally and starts a new frame with lable 0.

Reset
REQ-027 While rst_n=1: valid, frame_done, sop_err, lable and all x* = 0; the slot and group counters = 0; capture registers are cleared.
REQ-028 Reset asserted mid-group discards the partial group; the first sample after reset is slot 0 of group 0, whether or not in_sop is asserted.

Structure
REQ-029 A shared package fft_pkg shall hold DATA_WIDTH default, GROUPS default, the LABEL_W derivation, and a complex-sample struct type {re, im}.
REQ-030 The block is a single module; no sub-module is required, and the capture/slot logic stays inline.

Verification
REQ-031 Stream 8192 samples back-to-back with in_sop on the first, sample k = (re=k, im=-k) -> 2048 valid pulses every 4 cycles, group g carries x0..x3 = samples 4g..4g+3, lable = g, and frame_done occurs only at g = 2047.
REQ-032 Same stream with in_valid deasserted for 3 cycles after every second sample -> identical packed data and lable sequence, and valid asserted only after each slot-3 sample.
REQ-033 Send 6 samples, then in_sop plus 4 samples -> sop_err pulse, one group with lable=0 containing the 4 post-sop samples, and the first partial data never output.
REQ-034 Assert reset after 2 samples of group 5, then send 4 samples -> valid with lable=0 and the new samples, and all outputs zero during reset.
REQ-035 Feed extreme values (re=+2^20-1, im=-2^20) -> bit-exact on the output, and x*=0 on every cycle with valid=0.
REQ-036 Run two consecutive frames with in_sop at sample 8192 -> the second frame restarts at lable=0 with no sop_err.
